// File: rtl/tdm_demux2.sv
// tdm_demux2: two-channel TDM receiver; tracks slot timing and samples the shared line mid-slot.
// Optional build macro TDM_DEMUX_HOLD_EN keeps each channel's last sample across slot changes.
`timescale 1ns/1ps
module tdm_demux2 #(
  parameter int SLOT_LEN = 4,
  parameter int WIDTH    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic             validA,
  output logic             validB,
  output logic             sel_out
);

  localparam int            CW   = (SLOT_LEN > 2) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CW-1:0] CAP  = CW'(SLOT_LEN / 2);
  localparam logic [CW-1:0] LAST = CW'(SLOT_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN_A = 2'd1;
  localparam logic [1:0] RUN_B = 2'd2;

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] outA_nx, outB_nx;
  logic             validA_nx, validB_nx;
  logic             in_a, in_b, step, cap, wrap;
  logic             clr_a, clr_b;

  always_comb begin
    in_a = (state == RUN_A);
    in_b = (state == RUN_B);
    step = (in_a || in_b) && en && !sync;
    cap  = step && (cnt == CAP);
    wrap = step && (cnt == LAST);
  end

`ifdef TDM_DEMUX_HOLD_EN
  assign clr_a = 1'b0;
  assign clr_b = 1'b0;
`else
  // A channel's output clears on the edge that leaves its slot; sync only leaves slot B.
  assign clr_a = wrap && in_a;
  assign clr_b = (wrap || sync) && in_b;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (sync) begin
      state_nx = RUN_A;
      cnt_nx   = '0;
    end else if (!(in_a || in_b)) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (step) begin
      if (wrap) begin
        cnt_nx   = '0;
        state_nx = in_a ? RUN_B : RUN_A;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  // With SLOT_LEN = 2 the capture edge is also the slot-leaving edge; capture wins.
  always_comb begin
    validA_nx = cap && in_a;
    validB_nx = cap && in_b;
    outA_nx   = outA;
    outB_nx   = outB;
    if (validA_nx)  outA_nx = din;
    else if (clr_a) outA_nx = '0;
    if (validB_nx)  outB_nx = din;
    else if (clr_b) outB_nx = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      outA   <= '0;
      outB   <= '0;
      validA <= 1'b0;
      validB <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      outA   <= outA_nx;
      outB   <= outB_nx;
      validA <= validA_nx;
      validB <= validB_nx;
    end
  end

  assign sel_out = in_b;

endmodule
